// File: rtl/seq_write_a_pkg.sv
// Shared NW definitions: default sizes, nucleotide codes and the loader FSM encoding.
// Both the sequence-A write path and the read-index logic import this package.
package seq_write_a_pkg;

    localparam int NW_N        = 128;
    localparam int NW_BIT_CHAR = 2;

    localparam logic [1:0] NUC_A = 2'd0;
    localparam logic [1:0] NUC_C = 2'd1;
    localparam logic [1:0] NUC_G = 2'd2;
    localparam logic [1:0] NUC_T = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_write_a.sv
// Streams sequence A into RAM A at indices 1..len, leaving index 0 for the gap border.
// Handshake: a character transfers on a rising edge where in_valid && in_ready; in_ready depends on state only.
module seq_write_a
    import seq_write_a_pkg::*;
#(
    parameter int N       = NW_N,
    parameter int BitAddr = $clog2(N + 1),
    parameter int BitChar = NW_BIT_CHAR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BitChar-1:0] in_char,
    input  logic               in_last,
    output logic               in_ready,
    output logic               we,
    output logic [BitAddr:0]   addr_w,
    output logic [BitChar-1:0] data_w,
    output logic [BitAddr:0]   len,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [1:0]         dbg_state
);

    localparam logic [BitAddr:0] N_IDX = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0] ONE   = (BitAddr + 1)'(1);

    logic [1:0]         r_state;
    logic [BitAddr:0]   r_cnt;
    logic               r_we;
    logic [BitAddr:0]   r_addr;
    logic [BitChar-1:0] r_data;
    logic [BitAddr:0]   r_len;
    logic               r_done;
    logic               r_overflow;
    logic               w_load;
    logic               w_accept;

    assign w_load   = (r_state == ST_LOAD);
    assign w_accept = in_valid && w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_len      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Write port is zeroed whenever no character was taken last cycle.
            r_we   <= w_accept;
            r_addr <= w_accept ? r_cnt : '0;
            r_data <= w_accept ? in_char : '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_cnt      <= ONE;
                        r_len      <= '0;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_state <= ST_DONE;
                            r_len   <= r_cnt;
                            r_done  <= 1'b1;
                        end else if (r_cnt == N_IDX) begin
                            // Full without a terminator: stop here rather than wrap.
                            r_state    <= ST_DONE;
                            r_len      <= N_IDX;
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_load;
    assign we        = r_we;
    assign addr_w    = r_addr;
    assign data_w    = r_data;
    assign len       = r_len;
    assign busy      = w_load || r_we;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_write_a.sv
// Bench for seq_write_a: one instance at N=128 and one at N=4, checked cycle by cycle
// against a reference built from the loading rules (characters land at 1..len).
module tb_seq_write_a;
  import seq_write_a_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] start, in_valid, in_last;
  logic [1:0] in_char [2];

  logic       ready0, we0, busy0, done0, ovf0;
  logic [8:0] addr0, len0;
  logic [1:0] data0, dbg0;
  logic       ready1, we1, busy1, done1, ovf1;
  logic [3:0] addr1, len1;
  logic [1:0] data1, dbg1;

  seq_write_a #(.N(128)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
    .in_char(in_char[0]), .in_last(in_last[0]), .in_ready(ready0), .we(we0),
    .addr_w(addr0), .data_w(data0), .len(len0), .busy(busy0), .done(done0),
    .overflow(ovf0), .dbg_state(dbg0)
  );

  seq_write_a #(.N(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
    .in_char(in_char[1]), .in_last(in_last[1]), .in_ready(ready1), .we(we1),
    .addr_w(addr1), .data_w(data1), .len(len1), .busy(busy1), .done(done1),
    .overflow(ovf1), .dbg_state(dbg1)
  );

  logic [1:0]      o_ready, o_we, o_busy, o_done, o_ovf;
  logic [1:0][8:0] o_addr, o_len;
  logic [1:0][1:0] o_data, o_dbg;
  assign o_ready = {ready1, ready0};
  assign o_we    = {we1, we0};
  assign o_busy  = {busy1, busy0};
  assign o_done  = {done1, done0};
  assign o_ovf   = {ovf1, ovf0};
  assign o_addr  = {9'(addr1), addr0};
  assign o_len   = {9'(len1), len0};
  assign o_data  = {data1, data0};
  assign o_dbg   = {dbg1, dbg0};

  // ---------------- reference model ----------------
  int nmax [2] = '{128, 4};
  int m_n [2];
  int m_len [2];
  bit m_load [2];
  bit m_done [2];
  bit m_ovf [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void reset_model();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_len[k] = 0; m_load[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end
  endfunction

  function automatic logic [8:0] exp_state(int k);
    return 9'(m_load[k] ? ST_LOAD : (m_done[k] ? ST_DONE : ST_IDLE));
  endfunction

  // ---------------- driver: one clock cycle on instance k ----------------
  task automatic step(int k, bit s, bit v, logic [1:0] c, bit l);
    bit acc;
    int ea;
    logic [1:0] ed;
    @(negedge clk);
    start[k] = s; in_valid[k] = v; in_char[k] = c; in_last[k] = l;
    chk("in_ready", 9'(o_ready[k]), 9'(m_load[k]));
    acc = m_load[k] && v;
    ea = 0;
    ed = 2'd0;
    if (m_load[k]) begin
      if (acc) begin
        m_n[k]++;
        ea = m_n[k];
        ed = c;
        if (l || m_n[k] == nmax[k]) begin
          m_load[k] = 0; m_done[k] = 1; m_len[k] = m_n[k]; m_ovf[k] = !l;
        end
      end
    end else if (s) begin
      m_load[k] = 1; m_n[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_len[k] = 0;
    end
    @(posedge clk);
    #1;
    chk("we", 9'(o_we[k]), 9'(acc));
    chk("addr_w", o_addr[k], 9'(ea));
    chk("data_w", 9'(o_data[k]), 9'(ed));
    chk("len", o_len[k], 9'(m_len[k]));
    chk("done", 9'(o_done[k]), 9'(m_done[k]));
    chk("overflow", 9'(o_ovf[k]), 9'(m_ovf[k]));
    chk("busy", 9'(o_busy[k]), 9'(m_load[k] || acc));
    chk("state", 9'(o_dbg[k]), exp_state(k));
  endtask

  task automatic check_all_zero(int k);
    chk("rst_we", 9'(o_we[k]), 9'd0);
    chk("rst_busy", 9'(o_busy[k]), 9'd0);
    chk("rst_done", 9'(o_done[k]), 9'd0);
    chk("rst_ready", 9'(o_ready[k]), 9'd0);
    chk("rst_addr", o_addr[k], 9'd0);
    chk("rst_len", o_len[k], 9'd0);
    chk("rst_ovf", 9'(o_ovf[k]), 9'd0);
  endtask

  // random load: length L, random gaps, stray start pulses that must be ignored
  task automatic random_load(int k, int L);
    int guard;
    bit v;
    step(k, 1'b1, 1'b0, 2'd0, 1'b0);
    guard = 0;
    while (m_load[k] && guard < 200) begin
      v = ($urandom_range(0, 3) != 0);
      step(k, ($urandom_range(0, 7) == 0), v, 2'($urandom_range(0, 3)),
           v && (m_n[k] + 1 == L));
      guard++;
    end
    chk("load_terminates", 9'(m_load[k]), 9'd0);
    step(k, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    start = '0; in_valid = '0; in_last = '0;
    in_char[0] = '0; in_char[1] = '0;
    rst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero(0);
    check_all_zero(1);
    @(negedge clk);
    rst = 1'b0;

    // G,A,T,C back to back
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_G, 0);
    step(0, 0, 1, NUC_A, 0);
    step(0, 0, 1, NUC_T, 0);
    step(0, 0, 1, NUC_C, 1);
    chk("gatc_len", o_len[0], 9'd4);
    step(0, 0, 1, NUC_G, 1);   // DONE without start: nothing accepted
    step(0, 0, 0, 2'd0, 0);

    // restart from DONE, single character
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_T, 1);
    chk("single_len", o_len[0], 9'd1);

    // valid pattern 1,0,0,1,1
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_C, 0);
    step(0, 0, 0, NUC_G, 1);
    step(0, 0, 0, NUC_G, 1);
    step(0, 0, 1, NUC_A, 0);
    step(0, 0, 1, NUC_G, 1);
    chk("gap_len", o_len[0], 9'd3);

    // start ignored during LOAD
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_A, 0);
    step(0, 0, 1, NUC_C, 0);
    step(0, 1, 0, 2'd0, 0);
    step(0, 1, 1, NUC_G, 0);
    step(0, 0, 1, NUC_T, 1);
    chk("ignore_start_len", o_len[0], 9'd4);

    // overflow on the N=4 instance: six characters, no terminator
    step(1, 1, 0, 2'd0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 2'(i), 0);
    chk("ovf_len", o_len[1], 9'd4);
    chk("ovf_flag", 9'(o_ovf[1]), 9'd1);

    // random loads on both instances
    for (int i = 0; i < 12; i++) random_load(0, $urandom_range(1, 12));
    for (int i = 0; i < 12; i++) random_load(1, $urandom_range(1, 7));

    // reset in the middle of a load, with a write pending
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_A, 0);
    step(0, 0, 1, NUC_G, 0);
    #1;
    rst = 1'b1;
    #1;
    reset_model();
    check_all_zero(0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, NUC_C, 1);   // no start yet: must not be accepted
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 1, NUC_T, 0);
    step(0, 0, 1, NUC_C, 1);
    chk("post_rst_len", o_len[0], 9'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_write_a.md
SEQ_WRITE_A -- requirements
Module: seq_write_a

Interface
REQ-001 Parameter N, default 128, maximum length of sequence A in characters.
REQ-002 Parameter BitAddr, default $clog2(N+1), index width minus one; all indices are BitAddr+1 bits.
REQ-003 Parameter BitChar, default 2, width of one encoded nucleotide.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins loading a new sequence A.
REQ-007 in_valid  input  1  in_char/in_last hold a valid character.
REQ-008 in_char  input  BitChar  encoded character.
REQ-009 in_last  input  1  current character is the final one of the sequence.
REQ-010 in_ready  output  1  block accepts a character this cycle.
REQ-011 we  output  1  write strobe to RAM A.
REQ-012 addr_w  output  BitAddr+1  RAM A write index.
REQ-013 data_w  output  BitChar  RAM A write data.
REQ-014 len  output  BitAddr+1  number of characters written in the last completed load.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  level; sequence A is complete in RAM and len is valid.
REQ-017 overflow  output  1  level; the load was truncated at N characters without in_last.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-019 In IDLE, a start pulse SHALL move the FSM to LOAD, set the internal counter to 1, and clear done, overflow and len.
REQ-020 In DONE, a start pulse SHALL behave as in IDLE (restart); without start, the FSM SHALL remain in DONE.
REQ-021 In LOAD, start SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in LOAD, as a registered state decode with no combinational dependence on in_valid.
REQ-023 A character SHALL be accepted in a cycle only when in_valid and in_ready are both 1.
REQ-024 On acceptance, the block SHALL drive we=1, addr_w equal to the counter and data_w equal to in_char in the following cycle (registered, latency 1).
REQ-025 On acceptance, the counter SHALL then increment by 1.
REQ-026 Index 0 SHALL never be written, because row/column 0 is the gap border; characters SHALL occupy indices 1..len.
REQ-027 we SHALL be 0 in every cycle without a preceding acceptance.
REQ-028 When we=0, addr_w SHALL be 0 and data_w SHALL be 0.
REQ-029 On acceptance with in_last=1, the FSM SHALL go to DONE and len SHALL take the counter value; done SHALL rise in the same cycle as that final we.
REQ-030 On acceptance at counter==N with in_last=0, the FSM SHALL go to DONE, len SHALL be N and overflow SHALL be 1; no further characters SHALL be accepted.
REQ-031 The counter SHALL never exceed N and SHALL never wrap.
REQ-032 busy SHALL equal (state==LOAD) or (we==1).
REQ-033 Gaps in in_valid SHALL stall the load without any write and without a state change.

Reset
REQ-034 Asserting rst at any time, including mid-LOAD, SHALL immediately force state IDLE, counter 0 and all outputs to 0.
REQ-035 A write pending in the cycle rst asserts SHALL be dropped.
REQ-036 After rst is released, the block SHALL wait for a new start before accepting characters.

Structure
REQ-037 N, BitAddr, BitChar, the nucleotide codes (A=0, C=1, G=2, T=3) and the FSM state encoding SHALL reside in the shared NW package used by the read-index logic.
REQ-038 The block SHALL be a single module; the index counter SHALL be inline logic, not a sub-module.
REQ-039 addr_w and the read index SHALL share the same BitAddr+1 width so that both can feed the RAM A port mux directly.

Verification
REQ-040 Scenario: N=128; start, then four back-to-back characters G,A,T,C with in_last on the fourth -> we on 4 consecutive cycles at addr_w 1,2,3,4 with data 2,0,3,1; done=1 and len=4 in the cycle of the last we; overflow=0.
REQ-041 Scenario: in_valid toggling 1,0,0,1,1 with in_last on the last beat -> exactly 3 writes at indices 1..3; len=3; no write in the idle cycles.
REQ-042 Scenario: N=4; feed 6 characters with no in_last -> 4 writes (indices 1..4); in_ready=0 after the 4th acceptance; len=4; overflow=1.
REQ-043 Scenario: start pulsed during LOAD after 2 characters -> ignored; the load continues at index 3.
REQ-044 Scenario: rst asserted after 2 accepted characters -> same-cycle we=0, busy=0, done=0; the next start restarts at index 1.
REQ-045 Scenario: start pulsed while in DONE with len=4 -> done=0, len=0 next cycle; a new single-character sequence yields len=1 at index 1.
